// File: rtl/face_det_pkg.sv
// ---------------------------------------------------------------------------
// face_det_pkg
// Shared definitions for the face-detection datapath: integral-image buffer
// geometry, classifier-bank limits and the classifier scheduler state
// encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package face_det_pkg;

   // Integral-image buffer geometry.
   localparam int II_ADDR_W = 15;
   localparam int II_WIDTH  = 160;
   localparam int II_HEIGHT = 120;

   // Upper bound on classifiers per bank. This keeps the 4-bit vote
   // accumulator from overflowing.
   localparam int MAX_CLS = 8;

   // Scheduler state encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_RUN    = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } sched_state_t;

   // Width of a classifier index. It is never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cls_next_sel.sv
// ---------------------------------------------------------------------------
// cls_next_sel
// Combinational search for the lowest set bit of a classifier mask that lies
// strictly above index i_k. Passing i_k = -1 yields the lowest set bit
// overall.
// Ports:
//   i_mask  in  N_CLS   classifier enable mask
//   i_k     in  IDX_W+1 signed start index (search is for bits above it)
//   o_idx   out IDX_W   found index (0 when o_none)
//   o_none  out 1       no qualifying bit exists
// ---------------------------------------------------------------------------
module cls_next_sel
   import face_det_pkg::*;
#(
   parameter int N_CLS = 4,
   parameter int IDX_W = idx_width(N_CLS)
)(
   input  logic [N_CLS-1:0]      i_mask,
   input  logic signed [IDX_W:0] i_k,
   output logic [IDX_W-1:0]      o_idx,
   output logic                  o_none
);

   int w_k;
   assign w_k = int'(i_k);

   // NOTE: every output of a combinational block gets a default first, so
   // no path through the block leaves a value held (no latch).
   always_comb begin
      o_idx  = '0;
      o_none = 1'b1;
      // The scan runs downward, so the lowest qualifying index is written last.
      for (int j = N_CLS - 1; j >= 0; j--) begin
         if (i_mask[j] && (j > w_k)) begin
            o_idx  = IDX_W'(j);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/classifier_scheduler.sv
// ---------------------------------------------------------------------------
// classifier_scheduler
// Runs each enabled Haar classifier in turn on the shared integral-image
// read port. It collects the per-classifier votes and reports a face/no-face
// decision at the end of each pass.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                in  1        request a pass (ignored while busy)
//   cls_mask             in  N_CLS    classifier enables, latched on start
//   vote_thr             in  4        face threshold, latched on start (0 acts as 1)
//   cls_rd_addr          in  N_CLS*ADDR_W  classifier read addresses
//   cls_detect_done      in  N_CLS    classifier done pulses
//   cls_detected_flag    in  N_CLS    classifier results
//   cls_detect_en        out N_CLS    one-hot run enable (registered)
//   buf_rd_addr          out ADDR_W   buffer address (selected classifier in RUN, else 0)
//   busy                 out 1        pass in progress
//   done                 out 1        end-of-pass pulse
//   face_detected        out 1        pass result
//   vote_count           out 4        votes in the last pass
//   timeout_err          out 1        a classifier timed out (sticky until next start)
// ---------------------------------------------------------------------------
module classifier_scheduler
   import face_det_pkg::*;
#(
   parameter int N_CLS   = 4,
   parameter int ADDR_W  = II_ADDR_W,
   parameter int TIMEOUT = 32
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [N_CLS-1:0]        cls_mask,
   input  logic [3:0]              vote_thr,
   input  logic [N_CLS*ADDR_W-1:0] cls_rd_addr,
   input  logic [N_CLS-1:0]        cls_detect_done,
   input  logic [N_CLS-1:0]        cls_detected_flag,
   output logic [N_CLS-1:0]        cls_detect_en,
   output logic [ADDR_W-1:0]       buf_rd_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    face_detected,
   output logic [3:0]              vote_count,
   output logic                    timeout_err
);

   localparam int IDX_W = idx_width(N_CLS);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   sched_state_t r_state, w_next;

   logic [N_CLS-1:0] r_mask;
   logic [3:0]       r_thr, r_acc;
   logic [IDX_W-1:0] r_k;
   logic [CNT_W-1:0] r_tmo_cnt;

   logic [N_CLS-1:0]  r_en, w_en_d;
   logic              r_busy, r_done, r_face, r_timeout_err;
   logic [3:0]        r_vote_count;

   logic [ADDR_W-1:0] w_addr [N_CLS];
   logic [IDX_W-1:0]  w_first_idx, w_next_idx;
   logic              w_first_none, w_next_none;
   logic signed [IDX_W:0] w_k_cur, w_k_first;
   logic              w_sel_done, w_sel_flag, w_tmo;
   logic [3:0]        w_thr_eff;
   logic [N_CLS-1:0]  w_sel_onehot;

   for (genvar g = 0; g < N_CLS; g++) begin : g_addr
      assign w_addr[g] = cls_rd_addr[g*ADDR_W +: ADDR_W];
   end

   assign w_k_cur      = {1'b0, r_k};
   assign w_k_first    = '1;           // -1: search from the bottom
   assign w_sel_done   = cls_detect_done[r_k];
   assign w_sel_flag   = cls_detected_flag[r_k];
   assign w_tmo        = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
   assign w_thr_eff    = (r_thr == 4'd0) ? 4'd1 : r_thr;
   assign w_sel_onehot = N_CLS'(1) << r_k;

   cls_next_sel #(.N_CLS(N_CLS), .IDX_W(IDX_W)) u_first_sel (
      .i_mask (cls_mask),
      .i_k    (w_k_first),
      .o_idx  (w_first_idx),
      .o_none (w_first_none)
   );

   cls_next_sel #(.N_CLS(N_CLS), .IDX_W(IDX_W)) u_next_sel (
      .i_mask (r_mask),
      .i_k    (w_k_cur),
      .o_idx  (w_next_idx),
      .o_none (w_next_none)
   );

   // State register.
   // NOTE: clocked state uses non-blocking assignment so every register
   // samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (start) w_next = w_first_none ? ST_FINISH : ST_SELECT;
         ST_SELECT: w_next = ST_RUN;
         ST_RUN:    if (w_sel_done || w_tmo) w_next = ST_GAP;
         ST_GAP:    w_next = w_next_none ? ST_FINISH : ST_SELECT;
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Output decode. The enable register tracks SELECT/RUN one cycle late.
   // This puts the rising edge in the first RUN cycle and makes the single
   // low cycle between classifiers coincide with SELECT. The buffer address
   // is a pure mux, so it adds no latency.
   always_comb begin
      w_en_d      = '0;
      buf_rd_addr = '0;
      if (r_state == ST_SELECT || r_state == ST_RUN) w_en_d = w_sel_onehot;
      if (r_state == ST_RUN) buf_rd_addr = w_addr[r_k];
   end

   // Datapath: latched pass parameters, classifier index, timeout, votes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask        <= '0;
         r_thr         <= '0;
         r_acc         <= '0;
         r_k           <= '0;
         r_tmo_cnt     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: if (start) begin
               r_mask        <= cls_mask;
               r_thr         <= vote_thr;
               r_acc         <= '0;
               r_k           <= w_first_idx;
               r_timeout_err <= 1'b0;
            end
            ST_SELECT: r_tmo_cnt <= '0;
            ST_RUN: begin
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
               // A done pulse arriving in the timeout cycle still counts.
               if (w_sel_done)  r_acc <= r_acc + {3'b000, w_sel_flag};
               else if (w_tmo)  r_timeout_err <= 1'b1;
            end
            ST_GAP: if (!w_next_none) r_k <= w_next_idx;
            default: ;
         endcase
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en         <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_face       <= 1'b0;
         r_vote_count <= '0;
      end else begin
         r_en   <= w_en_d;
         r_busy <= (w_next != ST_IDLE);
         r_done <= (r_state == ST_FINISH);
         if (r_state == ST_FINISH) begin
            r_vote_count <= r_acc;
            r_face       <= (r_acc >= w_thr_eff);
         end
      end
   end

   assign cls_detect_en = r_en;
   assign busy          = r_busy;
   assign done          = r_done;
   assign face_detected = r_face;
   assign vote_count    = r_vote_count;
   assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_classifier_scheduler.sv
module tb_classifier_scheduler;
   localparam int N_CLS   = 4;
   localparam int ADDR_W  = 15;
   localparam int TIMEOUT = 32;
   localparam int BUDGET  = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic [N_CLS-1:0] cls_mask = '0;
   logic [3:0] vote_thr = '0;
   logic [N_CLS*ADDR_W-1:0] cls_rd_addr;
   logic [N_CLS-1:0] cls_detect_done = '0;
   logic [N_CLS-1:0] cls_detected_flag = '0;
   logic [N_CLS-1:0] cls_detect_en;
   logic [ADDR_W-1:0] buf_rd_addr;
   logic busy, done, face_detected, timeout_err;
   logic [3:0] vote_count;

   classifier_scheduler #(.N_CLS(N_CLS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cls_mask(cls_mask),
      .vote_thr(vote_thr), .cls_rd_addr(cls_rd_addr),
      .cls_detect_done(cls_detect_done), .cls_detected_flag(cls_detected_flag),
      .cls_detect_en(cls_detect_en), .buf_rd_addr(buf_rd_addr), .busy(busy),
      .done(done), .face_detected(face_detected), .vote_count(vote_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   logic [ADDR_W-1:0] addr_tab [N_CLS] = '{15'h1abc, 15'h2345, 15'h3456, 15'h7001};

   // Classifier model controls.
   logic [N_CLS-1:0] m_flag = '0;
   logic [N_CLS-1:0] m_hang = '0;
   int m_lat = 11;
   bit m_spur = 1'b0;
   int m_cnt [N_CLS] = '{0, 0, 0, 0};

   // Pass monitors.
   int order_code, gaps_bad, onehot_bad, done_cnt, addr_bad, low_run;
   int addr_hits [N_CLS];
   bit seen_en;
   logic [N_CLS-1:0] prev_en = '0;
   logic rec_busy1, rec_te1;
   logic [N_CLS-1:0] rec_en2;

   int total = 0;
   int bad = 0;

   task automatic clear_mon();
      order_code = 0; gaps_bad = 0; onehot_bad = 0; done_cnt = 0;
      addr_bad = 0; low_run = 0; seen_en = 1'b0;
      for (int k = 0; k < N_CLS; k++) addr_hits[k] = 0;
   endtask

   // One clock: observe outputs just after the edge, then update the model.
   task automatic tick();
      int en_idx;
      @(posedge clk);
      #1;
      en_idx = -1;
      for (int k = 0; k < N_CLS; k++) if (cls_detect_en[k]) en_idx = k;
      if ($countones(cls_detect_en) > 1) onehot_bad++;
      if (cls_detect_en != '0 && prev_en == '0) begin
         order_code = order_code * 10 + en_idx + 1;
         if (seen_en && low_run != 1) gaps_bad++;
         seen_en = 1'b1;
      end
      if (cls_detect_en == '0) low_run++;
      else low_run = 0;
      if (done) done_cnt++;
      if (buf_rd_addr != '0) begin
         if (en_idx < 0) addr_bad++;
         else if (buf_rd_addr != addr_tab[en_idx]) addr_bad++;
         else addr_hits[en_idx]++;
      end
      prev_en = cls_detect_en;
      for (int k = 0; k < N_CLS; k++) begin
         if (cls_detect_en[k]) m_cnt[k]++;
         else m_cnt[k] = 0;
         cls_detect_done[k] = cls_detect_en[k] && (m_cnt[k] == m_lat) && !m_hang[k];
      end
      if (m_spur && cls_detect_en[1] && m_cnt[1] == 5) cls_detect_done[3] = 1'b1;
      cls_detected_flag = m_flag;
   endtask

   // Runs one pass; lat counts clock edges from the start edge (1) to done.
   task automatic do_pass(input logic [3:0] mask, input logic [3:0] thr, output int lat);
      clear_mon();
      cls_mask = mask; vote_thr = thr; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      rec_busy1 = busy; rec_te1 = timeout_err;
      tick();
      lat = 2;
      rec_en2 = cls_detect_en;
      while (!done && lat < BUDGET) begin
         tick();
         lat++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL pass_done_wait: no done within %0d cycles (mask %b)", BUDGET, mask);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      total++;
      if ({cls_detect_en, buf_rd_addr, busy, done, face_detected, vote_count, timeout_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got en=%b addr=%h busy=%b done=%b face=%b votes=%0d te=%b expected all 0",
                  cls_detect_en, buf_rd_addr, busy, done, face_detected, vote_count, timeout_err);
      end
      rst_n = 1'b1;
      m_flag = 4'b1111;
      cls_mask = 4'b1111; vote_thr = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      total++;
      if (cls_detect_en !== 4'b0001 || buf_rd_addr !== addr_tab[0]) begin
         bad++;
         $display("FAIL reset_pre_run: got en=%b addr=%h expected en=0001 addr=%h", cls_detect_en, buf_rd_addr, addr_tab[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (cls_detect_en !== '0 || buf_rd_addr !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: got en=%b addr=%h busy=%b expected all 0", cls_detect_en, buf_rd_addr, busy);
      end
      clear_mon();
      tick(); tick();
      rst_n = 1'b1;
      repeat (3) tick();
      total++;
      if (busy !== 1'b0 || done_cnt !== 0 || cls_detect_en !== '0) begin
         bad++;
         $display("FAIL reset_release: got busy=%b done_pulses=%0d en=%b expected 0 0 0", busy, done_cnt, cls_detect_en);
      end
   endtask

   task automatic test_full_pass();
      int lat;
      m_flag = 4'b1101; m_hang = '0; m_lat = 11;
      do_pass(4'b1111, 4'd3, lat);
      total++;
      if (lat !== 54) begin bad++; $display("FAIL full_latency: got %0d expected 54", lat); end
      total++;
      if (rec_busy1 !== 1'b1 || rec_en2 !== 4'b0001) begin
         bad++;
         $display("FAIL full_start_timing: got busy@1=%b en@2=%b expected 1 0001", rec_busy1, rec_en2);
      end
      total++;
      if (order_code !== 1234 || gaps_bad !== 0 || onehot_bad !== 0) begin
         bad++;
         $display("FAIL full_enable_seq: got order=%0d bad_gaps=%0d multi_hot=%0d expected 1234 0 0", order_code, gaps_bad, onehot_bad);
      end
      total++;
      if (vote_count !== 4'd3 || face_detected !== 1'b1 || timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL full_result: got votes=%0d face=%b te=%b expected 3 1 0", vote_count, face_detected, timeout_err);
      end
      repeat (3) tick();
      total++;
      if (done_cnt !== 1 || addr_bad !== 0) begin
         bad++;
         $display("FAIL full_done_pulse: got done_pulses=%0d addr_errors=%0d expected 1 0", done_cnt, addr_bad);
      end
   endtask

   task automatic test_sparse();
      int lat;
      m_flag = 4'b0101;
      do_pass(4'b0101, 4'd2, lat);
      total++;
      if (lat !== 28 || order_code !== 13) begin
         bad++;
         $display("FAIL sparse_seq: got lat=%0d order=%0d expected 28 13", lat, order_code);
      end
      total++;
      if (addr_hits[0] !== 11 || addr_hits[2] !== 11 || addr_hits[1] + addr_hits[3] !== 0 || addr_bad !== 0) begin
         bad++;
         $display("FAIL sparse_addr: got hits=%0d,%0d,%0d,%0d errors=%0d expected 11,0,11,0 0",
                  addr_hits[0], addr_hits[1], addr_hits[2], addr_hits[3], addr_bad);
      end
      total++;
      if (vote_count !== 4'd2 || face_detected !== 1'b1) begin
         bad++;
         $display("FAIL sparse_result: got votes=%0d face=%b expected 2 1", vote_count, face_detected);
      end
   endtask

   task automatic test_timeout();
      int lat;
      m_flag = 4'b1111; m_hang = 4'b0010;
      do_pass(4'b1111, 4'd3, lat);
      m_hang = '0;
      total++;
      if (lat !== 75 || order_code !== 1234) begin
         bad++;
         $display("FAIL timeout_seq: got lat=%0d order=%0d expected 75 1234", lat, order_code);
      end
      total++;
      if (addr_hits[1] !== TIMEOUT || addr_hits[2] !== 11) begin
         bad++;
         $display("FAIL timeout_run_len: got run1=%0d run2=%0d expected %0d 11", addr_hits[1], addr_hits[2], TIMEOUT);
      end
      total++;
      if (timeout_err !== 1'b1 || vote_count !== 4'd3 || face_detected !== 1'b1) begin
         bad++;
         $display("FAIL timeout_result: got te=%b votes=%0d face=%b expected 1 3 1", timeout_err, vote_count, face_detected);
      end
   endtask

   task automatic test_vote_thr();
      int lat;
      // Follows the timeout pass, so the start here must clear timeout_err.
      m_flag = 4'b0001;
      do_pass(4'b0001, 4'd0, lat);
      total++;
      if (rec_te1 !== 1'b0 || lat !== 15) begin
         bad++;
         $display("FAIL thr0_start: got te_after_start=%b lat=%0d expected 0 15", rec_te1, lat);
      end
      total++;
      if (vote_count !== 4'd1 || face_detected !== 1'b1) begin
         bad++;
         $display("FAIL thr0_result: got votes=%0d face=%b expected 1 1", vote_count, face_detected);
      end
      m_flag = 4'b1101;
      do_pass(4'b1111, 4'd4, lat);
      total++;
      if (vote_count !== 4'd3 || face_detected !== 1'b0) begin
         bad++;
         $display("FAIL thr4_result: got votes=%0d face=%b expected 3 0", vote_count, face_detected);
      end
   endtask

   task automatic test_mask_zero();
      int lat;
      do_pass(4'b0000, 4'd5, lat);
      total++;
      if (lat !== 2 || rec_busy1 !== 1'b1 || order_code !== 0) begin
         bad++;
         $display("FAIL mask0_timing: got lat=%0d busy@1=%b order=%0d expected 2 1 0", lat, rec_busy1, order_code);
      end
      total++;
      if (vote_count !== 4'd0 || face_detected !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mask0_result: got votes=%0d face=%b busy=%b expected 0 0 0", vote_count, face_detected, busy);
      end
   endtask

   task automatic test_done_timeout_tie();
      int lat;
      m_flag = 4'b0001; m_lat = TIMEOUT;
      do_pass(4'b0001, 4'd1, lat);
      m_lat = 11;
      total++;
      if (lat !== 36 || vote_count !== 4'd1 || timeout_err !== 1'b0 || face_detected !== 1'b1) begin
         bad++;
         $display("FAIL tie_result: got lat=%0d votes=%0d te=%b face=%b expected 36 1 0 1", lat, vote_count, timeout_err, face_detected);
      end
   endtask

   task automatic test_start_busy();
      int lat;
      m_flag = 4'b0000;
      clear_mon();
      cls_mask = 4'b0001; vote_thr = 4'd1; start = 1'b1;
      tick();
      lat = 1;
      // Keep requesting a different pass through SELECT/RUN/GAP/FINISH.
      cls_mask = 4'b1111; vote_thr = 4'd0;
      while (!done && lat < BUDGET) begin
         tick();
         lat++;
      end
      start = 1'b0;
      total++;
      if (lat !== 15 || order_code !== 1 || vote_count !== 4'd0 || face_detected !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_ignored: got lat=%0d order=%0d votes=%0d face=%b expected 15 1 0 0",
                  lat, order_code, vote_count, face_detected);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_finish: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      m_flag = 4'b0101;
      do_pass(4'b0001, 4'd1, lat);
      // The next start lands in the IDLE cycle that shows done.
      do_pass(4'b0100, 4'd1, lat);
      total++;
      if (rec_busy1 !== 1'b1 || lat !== 15 || order_code !== 3 || vote_count !== 4'd1) begin
         bad++;
         $display("FAIL b2b_second: got busy@1=%b lat=%0d order=%0d votes=%0d expected 1 15 3 1",
                  rec_busy1, lat, order_code, vote_count);
      end
   endtask

   task automatic test_isolation();
      int lat;
      m_flag = 4'b1000; m_spur = 1'b1;
      do_pass(4'b0010, 4'd1, lat);
      m_spur = 1'b0;
      total++;
      if (lat !== 15 || addr_hits[1] !== 11 || vote_count !== 4'd0 || face_detected !== 1'b0) begin
         bad++;
         $display("FAIL isolation: got lat=%0d run=%0d votes=%0d face=%b expected 15 11 0 0",
                  lat, addr_hits[1], vote_count, face_detected);
      end
   endtask

   initial begin
      for (int k = 0; k < N_CLS; k++) cls_rd_addr[k*ADDR_W +: ADDR_W] = addr_tab[k];
      clear_mon();
      test_reset();
      test_full_pass();
      test_sparse();
      test_timeout();
      test_vote_thr();
      test_mask_zero();
      test_done_timeout_tie();
      test_start_busy();
      test_back_to_back();
      test_isolation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
